// File: rtl/cover_toggle_collector_if.sv
// Stream and status bundle between the toggle cover collector and its harness.
// master = collector side, slave = harness/consumer side.
interface cover_toggle_collector_if #(
  parameter int unsigned WIDTH = 7
);
  logic [WIDTH-1:0] valid;
  logic             enable;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_index;
  logic [WIDTH-1:0] hit_map;
  logic [6:0]       hit_count;
  logic             all_hit;

  modport master (
    input  valid, enable, clear, out_ready,
    output out_valid, out_index, hit_map, hit_count, all_hit
  );

  modport slave (
    output valid, enable, clear, out_ready,
    input  out_valid, out_index, hit_map, hit_count, all_hit
  );
endinterface

// File: rtl/cover_toggle_collector.sv
// Sticky toggle-cover collector: records first hits per bit and streams each
// hit point's global index exactly once per clear epoch over valid/ready.
module cover_toggle_collector #(
  parameter logic [63:0] COVER_INDEX = 64'd0,
  parameter int unsigned WIDTH       = 7,
  parameter int unsigned COVER_TOTAL = 38253
) (
  input logic                      clock,
  input logic                      reset_n,
  cover_toggle_collector_if.master bus
);

  if (WIDTH < 1 || WIDTH > 64 || COVER_TOTAL < WIDTH) begin : g_param_check
    $error("cover_toggle_collector: WIDTH must be 1..64 and not exceed COVER_TOTAL");
  end

  logic [WIDTH-1:0] hit_map_q;
  logic [WIDTH-1:0] pending_q;
  logic [6:0]       hit_count_q;
  logic             out_valid_q;
  logic [63:0]      out_index_q;

  logic [WIDTH-1:0] new_hits;
  logic [WIDTH-1:0] pick;
  logic [63:0]      pick_index;
  logic             load;

  function automatic logic [6:0] popcount(input logic [WIDTH-1:0] v);
    logic [6:0] n;
    n = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      n = n + 7'(v[i]);
    end
    return n;
  endfunction

  always_comb begin
    new_hits   = bus.valid & ~hit_map_q & {WIDTH{bus.enable}};
    load       = !out_valid_q || bus.out_ready;
    // Two's-complement trick isolates the lowest pending bit as a one-hot.
    pick       = pending_q & (~pending_q + WIDTH'(1));
    pick_index = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (pick[i]) begin
        pick_index = 64'(i);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_map_q   <= '0;
      pending_q   <= '0;
      hit_count_q <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
    end else if (bus.clear) begin
      hit_map_q   <= '0;
      pending_q   <= '0;
      hit_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      hit_map_q   <= hit_map_q | new_hits;
      hit_count_q <= hit_count_q + popcount(new_hits);
      if (load) begin
        // Slot refills only from already-registered pending; this cycle's hits wait one cycle.
        out_valid_q <= |pending_q;
        if (|pending_q) begin
          out_index_q <= COVER_INDEX + pick_index;
        end
        pending_q <= (pending_q & ~pick) | new_hits;
      end else begin
        pending_q <= pending_q | new_hits;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_index = out_index_q;
  assign bus.hit_map   = hit_map_q;
  assign bus.hit_count = hit_count_q;
  assign bus.all_hit   = &hit_map_q;

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Randomized bench for cover_toggle_collector with an array/queue reference
// model and a separate monitor comparing every cycle against it.
module tb_cover_toggle_collector;
  localparam int unsigned WIDTH = 7;
  localparam logic [63:0] CI    = 64'd1000;
  localparam int unsigned TOTAL = 38253;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  cover_toggle_collector_if #(.WIDTH(WIDTH)) bus ();

  cover_toggle_collector #(
    .COVER_INDEX (CI),
    .WIDTH       (WIDTH),
    .COVER_TOTAL (TOTAL)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: written only by the model process.
  bit          m_hit [WIDTH];
  bit          m_pend[WIDTH];
  logic [63:0] exp_q[$];
  int          drop_at = 0;

  // Monitor state: written only by the monitor process.
  int rd = 0;
  bit final_done = 0;

  // Stimulus-owned flag.
  bit done = 0;

  function automatic logic [WIDTH-1:0] model_map();
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) m[i] = m_hit[i];
    return m;
  endfunction

  function automatic int model_count();
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(m_hit[i]);
    return n;
  endfunction

  function automatic int pend_count();
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  // Model: first hits become pending; a free slot takes the lowest pending
  // point known before this edge; clear/reset discard anything not accepted.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n || bus.clear) begin
      for (int i = 0; i < WIDTH; i++) begin
        m_hit[i]  = 1'b0;
        m_pend[i] = 1'b0;
      end
      drop_at = exp_q.size();
    end else begin
      int  eff_rd;
      bit  found;
      eff_rd = (rd > drop_at) ? rd : drop_at;
      if (eff_rd >= exp_q.size()) begin
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
          if (!found && m_pend[i]) begin
            exp_q.push_back(CI + 64'(i));
            m_pend[i] = 1'b0;
            found     = 1'b1;
          end
        end
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (bus.enable && bus.valid[i] && !m_hit[i]) begin
          m_hit[i]  = 1'b1;
          m_pend[i] = 1'b1;
        end
      end
    end
  end

  // Monitor: owns the counters and the scoreboard read pointer.
  initial begin
    forever begin
      @(negedge clock or negedge reset_n);
      #1;
      if (rd < drop_at) rd = drop_at;
      if (!reset_n) begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0h want 0", bus.out_valid); end
        checks++; if (bus.out_index !== 64'd0) begin errors++; $display("FAIL rst_out_index got %0h want 0", bus.out_index); end
        checks++; if (bus.hit_map !== '0) begin errors++; $display("FAIL rst_hit_map got %0h want 0", bus.hit_map); end
        checks++; if (bus.hit_count !== 7'd0) begin errors++; $display("FAIL rst_hit_count got %0d want 0", bus.hit_count); end
        checks++; if (bus.all_hit !== 1'b0) begin errors++; $display("FAIL rst_all_hit got %0h want 0", bus.all_hit); end
      end else begin
        logic [WIDTH-1:0] em;
        int               ec;
        em = model_map();
        ec = model_count();
        checks++; if (bus.hit_map !== em) begin errors++; $display("FAIL hit_map got %0h want %0h", bus.hit_map, em); end
        checks++; if (bus.hit_count !== 7'(ec)) begin errors++; $display("FAIL hit_count got %0d want %0d", bus.hit_count, ec); end
        checks++; if (bus.all_hit !== (ec == WIDTH)) begin errors++; $display("FAIL all_hit got %0h want %0h", bus.all_hit, (ec == WIDTH)); end
        if (rd < exp_q.size()) begin
          checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL out_valid got %0h want 1", bus.out_valid); end
          checks++; if (bus.out_index !== exp_q[rd]) begin errors++; $display("FAIL out_index got %0d want %0d", bus.out_index, exp_q[rd]); end
          checks++; if (!(bus.out_index < 64'(TOTAL))) begin errors++; $display("FAIL index_range got %0d want below %0d", bus.out_index, TOTAL); end
          if (bus.out_ready) rd++;
        end else begin
          checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL out_valid_idle got %0h want 0", bus.out_valid); end
        end
      end
      if (done && !final_done) begin
        final_done = 1'b1;
        checks++; if (pend_count() != 0 || rd < exp_q.size()) begin
          errors++; $display("FAIL drained got pending=%0d unread=%0d want 0 and 0", pend_count(), exp_q.size() - rd);
        end
      end
    end
  end

  task automatic cyc(input logic [WIDTH-1:0] v, input logic en, input logic clr, input logic rdy);
    @(negedge clock);
    bus.valid     = v;
    bus.enable    = en;
    bus.clear     = clr;
    bus.out_ready = rdy;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) cyc('0, 1'b1, 1'b0, rdy);
  endtask

  initial begin
    bus.valid     = '0;
    bus.enable    = 1'b1;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Single point, then a repeat of an already-hit point.
    cyc(7'h04, 1'b1, 1'b0, 1'b1); idle(4, 1'b1);
    cyc(7'h01, 1'b1, 1'b0, 1'b1); idle(3, 1'b1);
    cyc(7'h01, 1'b1, 1'b0, 1'b1); idle(3, 1'b1);

    // All points at once: back-to-back ascending drain.
    cyc('0, 1'b1, 1'b1, 1'b1);
    cyc(7'h7F, 1'b1, 1'b0, 1'b1); idle(9, 1'b1);

    // Backpressure holds the slot.
    cyc('0, 1'b1, 1'b1, 1'b1);
    cyc(7'h11, 1'b1, 1'b0, 1'b0); idle(5, 1'b0); idle(3, 1'b1);

    // Clear beats a same-cycle hit.
    cyc(7'h02, 1'b1, 1'b1, 1'b1); idle(1, 1'b1);
    cyc(7'h02, 1'b1, 1'b0, 1'b1); idle(3, 1'b1);

    // Disabled sampling.
    repeat (3) cyc(7'h7F, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Async reset in the middle of a drain.
    cyc('0, 1'b1, 1'b1, 1'b1);
    cyc(7'h7F, 1'b1, 1'b0, 1'b1); idle(3, 1'b1);
    @(negedge clock);
    #3 reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    idle(4, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      logic [31:0] r;
      r = $urandom & $urandom & $urandom;
      cyc(r[WIDTH-1:0], ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0),
          ($urandom_range(0, 9) < 6));
    end

    idle(12, 1'b1);
    done = 1'b1;
    repeat (2) @(negedge clock);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
